// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/control/data carried between stages with stall hold,
// external and self-squash, and saturating stall/flush event counters.
module pipe_stage_reg #(
   parameter int unsigned DATA_W             = 64,
   parameter int unsigned CTRL_W             = 16,
   parameter int unsigned NSTALL             = 2,
   parameter int unsigned FLUSH_OVER_STALL   = 0,
   parameter int unsigned SELF_FLUSH         = 1,
   parameter int unsigned SELF_FLUSH_BIT     = 0,
   parameter int unsigned ZERO_DATA_ON_FLUSH = 1,
   parameter int unsigned CNT_W              = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTALL-1:0] stall_in,
   input  logic              flush_in,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              cnt_clr,
   output logic              valid_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam bit FOS_EN  = (FLUSH_OVER_STALL != 0);
   localparam bit SELF_EN = (SELF_FLUSH != 0);
   localparam bit ZERO_EN = (ZERO_DATA_ON_FLUSH != 0);

   logic stall;
   logic self_kill;
   logic flush_wins;
   logic hold;
   logic squash;

   // Action select: hold, squash or load, with flush/stall order set by FOS_EN
   always_comb begin
      stall      = |stall_in;
      self_kill  = SELF_EN && valid_out && ctrl_out[SELF_FLUSH_BIT] && !stall;
      flush_wins = FOS_EN && flush_in;
      hold       = stall && !flush_wins;
      squash     = flush_wins || (!stall && (flush_in || self_kill));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         ctrl_out  <= '0;
         data_out  <= '0;
      end else if (squash) begin
         valid_out <= 1'b0;
         ctrl_out  <= '0;
         data_out  <= ZERO_EN ? '0 : data_in;
      end else if (!hold) begin
         valid_out <= valid_in;
         // bubbles never carry control
         ctrl_out  <= valid_in ? ctrl_in : '0;
         data_out  <= data_in;
      end
   end

   // Saturating performance counters; clear beats increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hold && valid_out && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (squash && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations (stall-wins/4-bit counters and
// flush-wins/keep-data) checked against a table, directed sequences and a reference model.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  stall_in;
   logic        flush_in;
   logic        valid_in;
   logic [15:0] ctrl_in;
   logic [63:0] data_in;
   logic        cnt_clr;

   logic        a_valid, b_valid;
   logic [15:0] a_ctrl, b_ctrl;
   logic [63:0] a_data, b_data;
   logic [3:0]  a_scnt, a_fcnt;
   logic [15:0] b_scnt, b_fcnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.FLUSH_OVER_STALL(0), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
      .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
      .valid_out(a_valid), .ctrl_out(a_ctrl), .data_out(a_data),
      .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

   pipe_stage_reg #(.FLUSH_OVER_STALL(1), .ZERO_DATA_ON_FLUSH(0)) dut_b (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
      .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
      .valid_out(b_valid), .ctrl_out(b_ctrl), .data_out(b_data),
      .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

   typedef struct {
      logic        v;
      logic [15:0] c;
      logic [63:0] d;
      int unsigned sc;
      int unsigned fc;
   } mst_t;

   typedef struct {
      logic [1:0]  st;
      logic        fl;
      logic        vi;
      logic [15:0] ci;
      logic [63:0] di;
      logic        clr;
      logic        ev;
      logic [15:0] ec;
      logic [63:0] ed;
      int unsigned esc;
      int unsigned efc;
   } vec_t;

   mst_t ma, mb;
   vec_t tbl [19];

   // Reference: pick the action from the priority rules, then apply it
   function automatic mst_t mstep(input mst_t s, input logic [1:0] st, input logic fl,
                                  input logic vi, input logic [15:0] ci, input logic [63:0] di,
                                  input logic clr, input bit fos, input bit zdf,
                                  input int unsigned cmax);
      mst_t n;
      bit stalled;
      bit branch_held;
      int act; // 0 load, 1 hold, 2 squash
      n = s;
      stalled = (st != 2'b00);
      branch_held = s.v && s.c[0];
      if (fos && fl)                 act = 2;
      else if (stalled)              act = 1;
      else if (fl || branch_held)    act = 2;
      else                           act = 0;
      if (act == 2) begin
         n.v = 1'b0; n.c = '0; n.d = zdf ? 64'h0 : di;
      end else if (act == 0) begin
         n.v = vi; n.c = vi ? ci : 16'h0; n.d = di;
      end
      if (act == 1 && s.v && s.sc < cmax) n.sc = s.sc + 1;
      if (act == 2 && s.fc < cmax)        n.fc = s.fc + 1;
      if (clr) begin n.sc = 0; n.fc = 0; end
      return n;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic compare_model();
      chk("a_valid", 64'(a_valid), 64'(ma.v));
      chk("a_ctrl",  64'(a_ctrl),  64'(ma.c));
      chk("a_data",  a_data,       ma.d);
      chk("a_scnt",  64'(a_scnt),  64'(ma.sc));
      chk("a_fcnt",  64'(a_fcnt),  64'(ma.fc));
      chk("b_valid", 64'(b_valid), 64'(mb.v));
      chk("b_ctrl",  64'(b_ctrl),  64'(mb.c));
      chk("b_data",  b_data,       mb.d);
      chk("b_scnt",  64'(b_scnt),  64'(mb.sc));
      chk("b_fcnt",  64'(b_fcnt),  64'(mb.fc));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a_valid"}, 64'(a_valid), 64'h0);
      chk({tag, "_a_ctrl"},  64'(a_ctrl),  64'h0);
      chk({tag, "_a_data"},  a_data,       64'h0);
      chk({tag, "_a_scnt"},  64'(a_scnt),  64'h0);
      chk({tag, "_a_fcnt"},  64'(a_fcnt),  64'h0);
      chk({tag, "_b_valid"}, 64'(b_valid), 64'h0);
      chk({tag, "_b_data"},  b_data,       64'h0);
      chk({tag, "_b_scnt"},  64'(b_scnt),  64'h0);
   endtask

   task automatic model_reset();
      ma = '{1'b0, 16'h0, 64'h0, 0, 0};
      mb = '{1'b0, 16'h0, 64'h0, 0, 0};
   endtask

   // Called 1 time unit after a rising edge; drives, steps models, checks after next edge
   task automatic cycle(input logic [1:0] st, input logic fl, input logic vi,
                        input logic [15:0] ci, input logic [63:0] di, input logic clr);
      stall_in = st; flush_in = fl; valid_in = vi; ctrl_in = ci; data_in = di; cnt_clr = clr;
      ma = mstep(ma, st, fl, vi, ci, di, clr, 1'b0, 1'b1, 15);
      mb = mstep(mb, st, fl, vi, ci, di, clr, 1'b1, 1'b0, 65535);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   initial begin
      // Expected values for dut_a (stall wins, zeroed data, 4-bit counters)
      tbl[0]  = '{2'b00, 1'b0, 1'b1, 16'h00A4, 64'h1234, 1'b0, 1'b1, 16'h00A4, 64'h1234, 0, 0};
      tbl[1]  = '{2'b00, 1'b0, 1'b0, 16'hFFFF, 64'h5555, 1'b0, 1'b0, 16'h0000, 64'h5555, 0, 0};
      tbl[2]  = '{2'b00, 1'b0, 1'b1, 16'h0022, 64'hAAAA, 1'b0, 1'b1, 16'h0022, 64'hAAAA, 0, 0};
      tbl[3]  = '{2'b10, 1'b0, 1'b1, 16'h0033, 64'hBBBB, 1'b0, 1'b1, 16'h0022, 64'hAAAA, 1, 0};
      tbl[4]  = '{2'b10, 1'b1, 1'b0, 16'h0044, 64'hCCCC, 1'b0, 1'b1, 16'h0022, 64'hAAAA, 2, 0};
      tbl[5]  = '{2'b01, 1'b0, 1'b1, 16'h0055, 64'hDDDD, 1'b0, 1'b1, 16'h0022, 64'hAAAA, 3, 0};
      tbl[6]  = '{2'b00, 1'b0, 1'b1, 16'h0066, 64'hEEEE, 1'b0, 1'b1, 16'h0066, 64'hEEEE, 3, 0};
      tbl[7]  = '{2'b00, 1'b1, 1'b1, 16'h0077, 64'h1111, 1'b0, 1'b0, 16'h0000, 64'h0000, 3, 1};
      tbl[8]  = '{2'b00, 1'b0, 1'b1, 16'h0001, 64'h2222, 1'b0, 1'b1, 16'h0001, 64'h2222, 3, 1};
      tbl[9]  = '{2'b00, 1'b0, 1'b1, 16'h0010, 64'h3333, 1'b0, 1'b0, 16'h0000, 64'h0000, 3, 2};
      tbl[10] = '{2'b00, 1'b0, 1'b1, 16'h0003, 64'h4444, 1'b0, 1'b1, 16'h0003, 64'h4444, 3, 2};
      tbl[11] = '{2'b01, 1'b0, 1'b1, 16'h0005, 64'h5555, 1'b0, 1'b1, 16'h0003, 64'h4444, 4, 2};
      tbl[12] = '{2'b00, 1'b0, 1'b1, 16'h0009, 64'h6666, 1'b0, 1'b0, 16'h0000, 64'h0000, 4, 3};
      tbl[13] = '{2'b00, 1'b0, 1'b1, 16'h0007, 64'h7777, 1'b0, 1'b1, 16'h0007, 64'h7777, 4, 3};
      tbl[14] = '{2'b00, 1'b0, 1'b1, 16'h0009, 64'h8888, 1'b0, 1'b0, 16'h0000, 64'h0000, 4, 4};
      tbl[15] = '{2'b00, 1'b0, 1'b1, 16'h0008, 64'h9999, 1'b1, 1'b1, 16'h0008, 64'h9999, 0, 0};
      tbl[16] = '{2'b11, 1'b0, 1'b0, 16'h0000, 64'h0000, 1'b0, 1'b1, 16'h0008, 64'h9999, 1, 0};
      tbl[17] = '{2'b00, 1'b0, 1'b0, 16'h0000, 64'h0000, 1'b0, 1'b0, 16'h0000, 64'h0000, 1, 0};
      tbl[18] = '{2'b01, 1'b0, 1'b0, 16'h0000, 64'h0000, 1'b0, 1'b0, 16'h0000, 64'h0000, 1, 0};

      rst = 1'b1; stall_in = 2'b00; flush_in = 1'b0; valid_in = 1'b0;
      ctrl_in = 16'h0; data_in = 64'h0; cnt_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("por");
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         cycle(tbl[i].st, tbl[i].fl, tbl[i].vi, tbl[i].ci, tbl[i].di, tbl[i].clr);
         chk($sformatf("tbl%0d_valid", i), 64'(a_valid), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d_ctrl", i),  64'(a_ctrl),  64'(tbl[i].ec));
         chk($sformatf("tbl%0d_data", i),  a_data,       tbl[i].ed);
         chk($sformatf("tbl%0d_scnt", i),  64'(a_scnt),  64'(tbl[i].esc));
         chk($sformatf("tbl%0d_fcnt", i),  64'(a_fcnt),  64'(tbl[i].efc));
      end

      // Flush-wins config squashes under stall, stall-wins config holds
      cycle(2'b00, 1'b0, 1'b1, 16'h0040, 64'hF00D, 1'b1);
      cycle(2'b01, 1'b1, 1'b1, 16'h0050, 64'hBEEF, 1'b0);
      chk("prio_a_valid", 64'(a_valid), 64'h1);
      chk("prio_a_fcnt",  64'(a_fcnt),  64'h0);
      chk("prio_b_valid", 64'(b_valid), 64'h0);
      chk("prio_b_ctrl",  64'(b_ctrl),  64'h0);
      chk("prio_b_data",  b_data,       64'hBEEF);
      chk("prio_b_fcnt",  64'(b_fcnt),  64'h1);

      // Saturation: 20 stall cycles on a valid entry
      cycle(2'b00, 1'b0, 1'b1, 16'h0020, 64'hCAFE, 1'b1);
      for (int i = 0; i < 20; i++)
         cycle(2'b10, 1'b0, 1'b1, 16'($urandom), {$urandom, $urandom}, 1'b0);
      chk("sat_a_scnt", 64'(a_scnt), 64'd15);
      chk("sat_b_scnt", 64'(b_scnt), 64'd20);
      chk("sat_a_data", a_data, 64'hCAFE);
      cycle(2'b10, 1'b0, 1'b1, 16'h0, 64'h0, 1'b1);
      chk("clr_a_scnt", 64'(a_scnt), 64'd0);
      cycle(2'b10, 1'b0, 1'b1, 16'h0, 64'h0, 1'b0);
      chk("clr_a_scnt_inc", 64'(a_scnt), 64'd1);

      // Async reset mid-cycle while holding a valid entry with stall_cnt=5
      cycle(2'b00, 1'b0, 1'b1, 16'h0040, 64'h1357, 1'b1);
      for (int i = 0; i < 5; i++) cycle(2'b01, 1'b0, 1'b1, 16'h0, 64'h0, 1'b0);
      chk("pre_rst_a_scnt", 64'(a_scnt), 64'd5);
      chk("pre_rst_a_valid", 64'(a_valid), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      stall_in = 2'b11; flush_in = 1'b1; valid_in = 1'b1; ctrl_in = 16'hFFFF; data_in = '1;
      @(posedge clk);
      #1;
      check_zero("held_rst");
      rst = 1'b0;
      model_reset();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [1:0] st;
         st = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         cycle(st, ($urandom_range(0, 5) == 0), 1'($urandom), 16'($urandom),
               {$urandom, $urandom}, ($urandom_range(0, 40) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
